// File: rtl/axil2iob_pkg.sv
// Shared AXI4-lite widths and response codes for the AXI4-lite to native bridge.
package axil2iob_pkg;

  localparam int AXI_PROT_W = 3;
  localparam int AXI_RESP_W = 2;

  localparam logic [AXI_RESP_W-1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/axil_chan_buf.sv
// One-entry channel buffer with full flag: captures on in_valid & in_ready,
// releases on pop. Ready is simply "not full".
module axil_chan_buf #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              pop,
  output logic [DATA_W-1:0] out_data,
  output logic              full
);

  logic              full_d, full_q;
  logic [DATA_W-1:0] data_d, data_q;

  // Next entry state: a pop frees the slot, a handshake fills it.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (pop) full_d = 1'b0;
    if (in_valid && !full_q) begin
      full_d = 1'b1;
      data_d = in_data;
    end
  end

  // Entry registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign in_ready = ~full_q;
  assign out_data = data_q;
  assign full     = full_q;

endmodule

// File: rtl/axil2iob.sv
// AXI4-lite slave to native (valid/addr/wdata/wstrb/rdata/ready) master bridge.
// AW, W and AR are buffered independently; one native transaction at a time.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a complete write (AW+W) or a read (AR)
// ST_WRITE | native write issued, waiting for ready
// ST_WRESP | bvalid asserted, waiting for bready
// ST_READ  | native read issued, waiting for ready
// ST_RRESP | rvalid asserted with captured rdata, waiting for rready
module axil2iob
  import axil2iob_pkg::*;
#(
  parameter int AXIL_ADDR_W = 32,
  parameter int AXIL_DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [AXIL_ADDR_W-1:0]   s_axil_awaddr,
  input  logic [AXI_PROT_W-1:0]    s_axil_awprot,
  input  logic                     s_axil_awvalid,
  output logic                     s_axil_awready,
  input  logic [AXIL_DATA_W-1:0]   s_axil_wdata,
  input  logic [AXIL_DATA_W/8-1:0] s_axil_wstrb,
  input  logic                     s_axil_wvalid,
  output logic                     s_axil_wready,
  output logic [AXI_RESP_W-1:0]    s_axil_bresp,
  output logic                     s_axil_bvalid,
  input  logic                     s_axil_bready,
  input  logic [AXIL_ADDR_W-1:0]   s_axil_araddr,
  input  logic [AXI_PROT_W-1:0]    s_axil_arprot,
  input  logic                     s_axil_arvalid,
  output logic                     s_axil_arready,
  output logic [AXIL_DATA_W-1:0]   s_axil_rdata,
  output logic [AXI_RESP_W-1:0]    s_axil_rresp,
  output logic                     s_axil_rvalid,
  input  logic                     s_axil_rready,
  output logic                     valid,
  output logic [AXIL_ADDR_W-1:0]   addr,
  output logic [AXIL_DATA_W-1:0]   wdata,
  output logic [AXIL_DATA_W/8-1:0] wstrb,
  input  logic [AXIL_DATA_W-1:0]   rdata,
  input  logic                     ready
);

  localparam int STRB_W = AXIL_DATA_W / 8;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WRITE, ST_WRESP, ST_READ, ST_RRESP
  } state_t;

  state_t                   state_d, state_q;
  logic                     prio_d, prio_q;   // 0: write wins a tie, 1: read wins
  logic [AXIL_DATA_W-1:0]   rdata_d, rdata_q;
  logic                     pop_wr, pop_rd;
  logic                     aw_full, w_full, ar_full;
  logic [AXIL_ADDR_W-1:0]   aw_addr, ar_addr;
  logic [AXIL_DATA_W+STRB_W-1:0] w_buf;
  logic [AXIL_DATA_W-1:0]   w_data;
  logic [STRB_W-1:0]        w_strb;
  logic                     wr_pend, rd_pend;
  logic                     unused_prot;

  assign unused_prot = ^{s_axil_awprot, s_axil_arprot};

  axil_chan_buf #(.DATA_W(AXIL_ADDR_W)) u_aw_buf (
    .clk(clk), .rst(rst),
    .in_data(s_axil_awaddr), .in_valid(s_axil_awvalid), .in_ready(s_axil_awready),
    .pop(pop_wr), .out_data(aw_addr), .full(aw_full)
  );

  axil_chan_buf #(.DATA_W(AXIL_DATA_W + STRB_W)) u_w_buf (
    .clk(clk), .rst(rst),
    .in_data({s_axil_wstrb, s_axil_wdata}), .in_valid(s_axil_wvalid), .in_ready(s_axil_wready),
    .pop(pop_wr), .out_data(w_buf), .full(w_full)
  );

  axil_chan_buf #(.DATA_W(AXIL_ADDR_W)) u_ar_buf (
    .clk(clk), .rst(rst),
    .in_data(s_axil_araddr), .in_valid(s_axil_arvalid), .in_ready(s_axil_arready),
    .pop(pop_rd), .out_data(ar_addr), .full(ar_full)
  );

  assign w_data  = w_buf[AXIL_DATA_W-1:0];
  assign w_strb  = w_buf[AXIL_DATA_W+STRB_W-1:AXIL_DATA_W];
  assign wr_pend = aw_full & w_full;
  assign rd_pend = ar_full;

  // Arbitration and sequencing; a zero-strobe write completes without a native access.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    rdata_d = rdata_q;
    pop_wr  = 1'b0;
    pop_rd  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_pend && (!rd_pend || !prio_q)) begin
          prio_d = 1'b1;
          if (w_strb == '0) begin
            pop_wr  = 1'b1;
            state_d = ST_WRESP;
          end else begin
            state_d = ST_WRITE;
          end
        end else if (rd_pend) begin
          prio_d  = 1'b0;
          state_d = ST_READ;
        end
      end
      ST_WRITE: begin
        if (ready) begin
          pop_wr  = 1'b1;
          state_d = ST_WRESP;
        end
      end
      ST_READ: begin
        if (ready) begin
          rdata_d = rdata;
          pop_rd  = 1'b1;
          state_d = ST_RRESP;
        end
      end
      ST_WRESP: if (s_axil_bready) state_d = ST_IDLE;
      ST_RRESP: if (s_axil_rready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, tie-break flag and captured read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      prio_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      rdata_q <= rdata_d;
    end
  end

  assign valid         = (state_q == ST_WRITE) || (state_q == ST_READ);
  assign addr          = (state_q == ST_WRITE) ? aw_addr :
                         (state_q == ST_READ)  ? ar_addr : '0;
  assign wdata         = (state_q == ST_WRITE) ? w_data : '0;
  assign wstrb         = (state_q == ST_WRITE) ? w_strb : '0;
  assign s_axil_bvalid = (state_q == ST_WRESP);
  assign s_axil_rvalid = (state_q == ST_RRESP);
  assign s_axil_rdata  = rdata_q;
  assign s_axil_bresp  = AXI_RESP_OKAY;
  assign s_axil_rresp  = AXI_RESP_OKAY;

endmodule

// File: tb/tb_axil2iob.sv
// Directed bench for axil2iob: vector table for single transactions plus
// hand-written sequences for ordering, stall, arbitration and reset cases.
module tb_axil2iob;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_axil_awaddr = '0;
  logic [2:0]  s_axil_awprot = '0;
  logic        s_axil_awvalid = 1'b0;
  logic        s_axil_awready;
  logic [31:0] s_axil_wdata = '0;
  logic [3:0]  s_axil_wstrb = '0;
  logic        s_axil_wvalid = 1'b0;
  logic        s_axil_wready;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_bvalid;
  logic        s_axil_bready = 1'b1;
  logic [31:0] s_axil_araddr = '0;
  logic [2:0]  s_axil_arprot = '0;
  logic        s_axil_arvalid = 1'b0;
  logic        s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid;
  logic        s_axil_rready = 1'b1;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata = '0;
  logic        ready = 1'b0;

  axil2iob #(.AXIL_ADDR_W(32), .AXIL_DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata), .ready(ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          first_c;
    int          done_c;
  } nat_t;

  nat_t        nat_q[$];
  int          slv_wait = 0;
  logic [31:0] slv_rdata = '0;
  int          wcnt = 0;
  int          vstart = 0;
  int          b_cnt = 0, r_cnt = 0, b_cyc = 0, r_cyc = 0;
  logic [1:0]  b_resp = '0, r_resp = '0;
  logic [31:0] r_data = '0;

  // Native slave model and AXI response logger, both evaluated mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      ready = 1'b0;
      wcnt  = 0;
    end else if (valid && !ready) begin
      if (wcnt == 0) vstart = cyc;
      if (wcnt >= slv_wait) begin
        ready = 1'b1;
        rdata = slv_rdata;
        nat_q.push_back('{addr, wdata, wstrb, vstart, cyc});
        wcnt = 0;
      end else begin
        wcnt = wcnt + 1;
      end
    end else begin
      ready = 1'b0;
      wcnt  = 0;
    end
    if (s_axil_bvalid && s_axil_bready) begin
      b_cnt = b_cnt + 1; b_cyc = cyc; b_resp = s_axil_bresp;
    end
    if (s_axil_rvalid && s_axil_rready) begin
      r_cnt = r_cnt + 1; r_cyc = cyc; r_resp = s_axil_rresp; r_data = s_axil_rdata;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_resp(input bit is_rd, input int n0, input string nm);
    bit got = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if ((is_rd ? r_cnt : b_cnt) > n0) begin
        got = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL %s: no response within 80 cycles, got count %0d, expected > %0d",
               nm, is_rd ? r_cnt : b_cnt, n0);
    end
  endtask

  // Present the selected channels for exactly one cycle (buffers assumed empty).
  task automatic issue(input bit do_aw, input bit do_w, input bit do_ar,
                       input logic [31:0] awa, input logic [31:0] wd, input logic [3:0] ws,
                       input logic [31:0] ara, output int t);
    @(posedge clk); #1;
    t = cyc;
    s_axil_awvalid = do_aw; s_axil_awaddr = awa;
    s_axil_wvalid  = do_w;  s_axil_wdata  = wd; s_axil_wstrb = ws;
    s_axil_arvalid = do_ar; s_axil_araddr = ara;
    @(posedge clk); #1;
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          wt;
    bit          exp_nat;
    int          exp_lat;
  } vec_t;

  vec_t vt[6];

  initial begin
    int t, nn, nb, nr, lat;
    bit ok;

    vt[0] = '{1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 0, 1'b1, 3};
    vt[1] = '{1'b1, 32'h0000_0004, 32'hA5A5_0000, 4'hC, 2, 1'b1, 5};
    vt[2] = '{1'b0, 32'h0000_0020, 32'h1234_5678, 4'h0, 3, 1'b1, 6};
    vt[3] = '{1'b0, 32'hFFFF_FFFC, 32'hCAFE_F00D, 4'h0, 0, 1'b1, 3};
    vt[4] = '{1'b1, 32'h0000_0040, 32'h0000_0011, 4'h0, 0, 1'b0, 2};
    vt[5] = '{1'b1, 32'hFFFF_FFFC, 32'h0BAD_CAFE, 4'h1, 1, 1'b1, 4};

    // Reset values while reset is held.
    #2;
    chk("reset_ctl", {valid, s_axil_bvalid, s_axil_rvalid,
                      s_axil_awready, s_axil_wready, s_axil_arready}, 6'b000111);
    chk("reset_data", {addr, wdata, wstrb, s_axil_rdata}, 100'h0);
    chk("reset_resp", {s_axil_bresp, s_axil_rresp}, 4'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Single transactions from the vector table.
    for (int i = 0; i < 6; i++) begin
      slv_wait  = vt[i].wt;
      slv_rdata = vt[i].data;
      nn = nat_q.size(); nb = b_cnt; nr = r_cnt;
      if (vt[i].wr) issue(1'b1, 1'b1, 1'b0, vt[i].addr, vt[i].data, vt[i].strb, 32'h0, t);
      else          issue(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, vt[i].addr, t);
      wait_resp(!vt[i].wr, vt[i].wr ? nb : nr, $sformatf("v%0d_resp", i));
      lat = vt[i].wr ? (b_cyc - t) : (r_cyc - t);
      chk($sformatf("v%0d_latency", i), lat, vt[i].exp_lat);
      chk($sformatf("v%0d_resp_code", i), vt[i].wr ? b_resp : r_resp, 2'b00);
      chk($sformatf("v%0d_nat_count", i), nat_q.size(), nn + (vt[i].exp_nat ? 1 : 0));
      if (vt[i].exp_nat && nat_q.size() > nn) begin
        chk($sformatf("v%0d_nat_addr", i), nat_q[nn].addr, vt[i].addr);
        chk($sformatf("v%0d_nat_wdata", i), nat_q[nn].wdata, vt[i].wr ? vt[i].data : 32'h0);
        chk($sformatf("v%0d_nat_wstrb", i), nat_q[nn].wstrb, vt[i].wr ? vt[i].strb : 4'h0);
        chk($sformatf("v%0d_valid_cycle", i), nat_q[nn].first_c - t, 2);
        chk($sformatf("v%0d_valid_len", i), nat_q[nn].done_c - nat_q[nn].first_c, vt[i].wt);
      end
      if (!vt[i].wr) chk($sformatf("v%0d_rdata", i), r_data, vt[i].data);
      repeat (2) @(posedge clk);
    end

    // W first, AW four cycles later.
    slv_wait = 0;
    nn = nat_q.size(); nb = b_cnt;
    issue(1'b0, 1'b1, 1'b0, 32'h0, 32'h7777_8888, 4'hF, 32'h0, t);
    chk("wfirst_wready_low", s_axil_wready, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    s_axil_awvalid = 1'b1; s_axil_awaddr = 32'h0000_0500;
    @(posedge clk); #1;
    s_axil_awvalid = 1'b0;
    chk("wfirst_no_early_valid", {valid, nat_q.size()}, {1'b0, nn});
    wait_resp(1'b0, nb, "wfirst_resp");
    chk("wfirst_nat_count", nat_q.size(), nn + 1);
    if (nat_q.size() > nn) begin
      chk("wfirst_valid_cycle", nat_q[nn].first_c - t, 6);
      chk("wfirst_nat_addr_data", {nat_q[nn].addr, nat_q[nn].wdata}, {32'h0000_0500, 32'h7777_8888});
    end
    chk("wfirst_b_cycle", b_cyc - t, 7);
    repeat (5) @(posedge clk);
    chk("wfirst_single_b", {b_cnt, nat_q.size()}, {nb + 1, nn + 1});

    // Read with wait states and a stalled R channel.
    s_axil_rready = 1'b0;
    slv_wait = 3; slv_rdata = 32'h1234_5678;
    nn = nat_q.size(); nr = r_cnt;
    issue(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h0000_0020, t);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (s_axil_rvalid) begin ok = 1'b1; break; end
    end
    chk("stall_rvalid_seen", ok, 1'b1);
    if (nat_q.size() > nn) begin
      chk("stall_valid_len", nat_q[nn].done_c - nat_q[nn].first_c, 3);
      chk("stall_nat_rd", {nat_q[nn].addr, nat_q[nn].wstrb}, {32'h0000_0020, 4'h0});
    end else begin
      chk("stall_nat_count", nat_q.size(), nn + 1);
    end
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk); #1;
      if (!s_axil_rvalid || s_axil_rdata !== 32'h1234_5678) ok = 1'b0;
    end
    chk("stall_rvalid_held", ok, 1'b1);
    chk("stall_no_early_accept", r_cnt, nr);
    @(posedge clk); #1 s_axil_rready = 1'b1;
    wait_resp(1'b1, nr, "stall_resp");
    chk("stall_rdata", r_data, 32'h1234_5678);
    @(negedge clk); #1;
    chk("stall_rvalid_drop", {s_axil_rvalid, r_cnt}, {1'b0, nr + 1});

    // Reset in the middle of a write that the slave never answers.
    slv_wait = 1000;
    nb = b_cnt;
    issue(1'b1, 1'b1, 1'b0, 32'h0000_2000, 32'hFEED_FACE, 4'hF, 32'h0, t);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (valid) begin ok = 1'b1; break; end
    end
    chk("rstmid_in_write", ok, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("rstmid_ctl", {valid, s_axil_bvalid, s_axil_rvalid,
                       s_axil_awready, s_axil_wready, s_axil_arready}, 6'b000111);
    chk("rstmid_data", {addr, wdata, wstrb, s_axil_rdata}, 100'h0);
    @(posedge clk); #1 rst = 1'b0;
    slv_wait = 0; slv_rdata = 32'h5A5A_1234;
    nn = nat_q.size(); nr = r_cnt;
    issue(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h0000_0030, t);
    wait_resp(1'b1, nr, "rstmid_read_resp");
    chk("rstmid_read", {r_data, r_resp}, {32'h5A5A_1234, 2'b00});
    chk("rstmid_read_lat", r_cyc - t, 3);
    chk("rstmid_no_b", b_cnt, nb);
    chk("rstmid_nat_count", nat_q.size(), nn + 1);

    // Simultaneous read and write: alternation, last served was a read.
    for (int r = 0; r < 2; r++) begin
      nn = nat_q.size(); nb = b_cnt; nr = r_cnt;
      slv_rdata = 32'hBEEF_0000 + r;
      issue(1'b1, 1'b1, 1'b1, 32'h100 + 32'(r * 16), 32'hC0DE_0000 + r, 4'hF,
            32'h200 + 32'(r * 16), t);
      wait_resp(1'b0, nb, $sformatf("alt%0d_b", r));
      wait_resp(1'b1, nr, $sformatf("alt%0d_r", r));
      chk($sformatf("alt%0d_resp", r), {b_resp, r_resp}, 4'h0);
      chk($sformatf("alt%0d_rdata", r), r_data, 32'hBEEF_0000 + r);
      if (nat_q.size() == nn + 2) begin
        chk($sformatf("alt%0d_first_is_write", r), {nat_q[nn].addr, nat_q[nn].wstrb},
            {32'h100 + 32'(r * 16), 4'hF});
        chk($sformatf("alt%0d_second_is_read", r), {nat_q[nn+1].addr, nat_q[nn+1].wstrb},
            {32'h200 + 32'(r * 16), 4'h0});
      end else begin
        chk($sformatf("alt%0d_nat_count", r), nat_q.size(), nn + 2);
      end
      repeat (2) @(posedge clk);
    end

    // After a lone write, a tie must go to the read.
    nb = b_cnt;
    issue(1'b1, 1'b1, 1'b0, 32'h300, 32'h3333_3333, 4'h3, 32'h0, t);
    wait_resp(1'b0, nb, "prio_lone_b");
    repeat (2) @(posedge clk);
    nn = nat_q.size(); nb = b_cnt; nr = r_cnt;
    issue(1'b1, 1'b1, 1'b1, 32'h500, 32'h5555_5555, 4'hF, 32'h400, t);
    wait_resp(1'b0, nb, "prio_tie_b");
    wait_resp(1'b1, nr, "prio_tie_r");
    if (nat_q.size() == nn + 2) begin
      chk("prio_tie_read_first", {nat_q[nn].addr, nat_q[nn].wstrb}, {32'h400, 4'h0});
      chk("prio_tie_write_second", {nat_q[nn+1].addr, nat_q[nn+1].wstrb}, {32'h500, 4'hF});
    end else begin
      chk("prio_tie_nat_count", nat_q.size(), nn + 2);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
